// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types, op encodings and arithmetic helper for the add/absdiff arbiter
package addsub_pkg;

    localparam logic OP_ADD     = 1'b0;
    localparam logic OP_ABSDIFF = 1'b1;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Operands arrive zero-extended; callers keep only the low WIDTH+1 bits.
    function automatic logic [31:0] absdiff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/addsub_rr_pick.sv
// rtl/addsub_rr_pick.sv - combinational round-robin picker, first set bit at or above rr_ptr with wrap
module addsub_rr_pick
    import addsub_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     grant_idx_o,
    output logic               any_grant_o
);

    int pos;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        pos         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr_i) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any_grant_o && (i == pos) && req_i[i]) begin
                    any_grant_o = 1'b1;
                    grant_o[i]  = 1'b1;
                    grant_idx_o = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// rtl/addsub_rr_arbiter.sv - round-robin shared add/absdiff unit; optional stats under ADDSUB_ARB_STATS_EN
module addsub_rr_arbiter
    import addsub_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_op,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       rsp_op,
    output logic [WIDTH:0]             rsp_result
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [7:0]                 op_count,
    output logic                       busy
`endif
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q;
    logic               op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH:0]     result_q, result_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               any_grant;
    logic               capture_en;
    logic               calc_en;
    logic               sel_op;
    logic [WIDTH-1:0]   sel_a, sel_b;

    addsub_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:     if (any_grant) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        rsp_valid  = 1'b0;
        capture_en = 1'b0;
        calc_en    = 1'b0;
        unique case (state_q)
            ARB: begin
                req_ready  = grant;
                capture_en = any_grant;
            end
            CALC:    calc_en   = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // AND-OR select on the one-hot grant so undriven slices of idle requesters never reach the registers.
    always_comb begin
        sel_op = 1'b0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[i];
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rr_ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
        if (op_q == OP_ADD) begin
            result_d = {1'b0, a_q} + {1'b0, b_q};
        end else begin
            result_d = (WIDTH + 1)'(absdiff(32'(a_q), 32'(b_q)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            if (capture_en) begin
                rr_ptr_q <= rr_ptr_d;
                id_q     <= grant_idx;
                op_q     <= sel_op;
                a_q      <= sel_a;
                b_q      <= sel_b;
            end
            if (calc_en) begin
                result_q <= result_d;
            end
        end
    end

    assign rsp_id     = id_q;
    assign rsp_op     = op_q;
    assign rsp_result = result_q;

`ifdef ADDSUB_ARB_STATS_EN
    logic [7:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (rsp_valid && rsp_ready && (op_count_q != 8'hFF)) begin
            op_count_d = op_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
    assign busy     = (state_q != ARB);
`endif

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// tb/tb_addsub_rr_arbiter.sv - directed vector bench for addsub_rr_arbiter
module tb_addsub_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_op;
    logic [4:0]  rsp_result;
`ifdef ADDSUB_ARB_STATS_EN
    logic [7:0]  op_count;
    logic        busy;
`endif

    addsub_rr_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_op     (rsp_op),
        .rsp_result (rsp_result)
`ifdef ADDSUB_ARB_STATS_EN
        ,
        .op_count   (op_count),
        .busy       (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[7];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic op, input logic [3:0] a, input logic [3:0] b);
        req_op[i]        = op;
        req_a[i*4 +: 4]  = a;
        req_b[i*4 +: 4]  = b;
    endtask

    initial begin
        vecs[0] = '{idx: 2, op: 1'b0, a: 4'd9,  b: 4'd7,  exp: 5'd16};
        vecs[1] = '{idx: 0, op: 1'b1, a: 4'd3,  b: 4'd12, exp: 5'd9};
        vecs[2] = '{idx: 0, op: 1'b1, a: 4'd12, b: 4'd3,  exp: 5'd9};
        vecs[3] = '{idx: 1, op: 1'b1, a: 4'd5,  b: 4'd5,  exp: 5'd0};
        vecs[4] = '{idx: 3, op: 1'b0, a: 4'd15, b: 4'd15, exp: 5'd30};
        vecs[5] = '{idx: 1, op: 1'b0, a: 4'd0,  b: 4'd0,  exp: 5'd0};
        vecs[6] = '{idx: 3, op: 1'b1, a: 4'd0,  b: 4'd15, exp: 5'd15};

        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        mid();
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_rsp_op", 32'(rsp_op), 0);
        chk("reset_rsp_result", 32'(rsp_result), 0);
        step();

        // single-requester vectors; other requesters' operand slices are left as X
        for (int v = 0; v < 7; v++) begin
            req_a = 'x;
            req_b = 'x;
            req_op = 'x;
            set_req(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b);
            req_valid = 4'(1 << vecs[v].idx);
            mid();
            chk("vec_req_ready", 32'(req_ready), 32'(1 << vecs[v].idx));
            chk("vec_arb_rsp_valid", 32'(rsp_valid), 0);
            step();
            req_valid = '0;
            mid();
            chk("vec_calc_rsp_valid", 32'(rsp_valid), 0);
            chk("vec_calc_req_ready", 32'(req_ready), 0);
            step();
            mid();
            chk("vec_rsp_valid", 32'(rsp_valid), 1);
            chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].idx));
            chk("vec_rsp_op", 32'(rsp_op), 32'(vecs[v].op));
            chk("vec_rsp_result", 32'(rsp_result), 32'(vecs[v].exp));
            step();
        end

        // fairness: all valid, rr_ptr is 0 after the last grant to 3
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(i), 4'(i + 1));
        req_valid = 4'hF;
        for (int g = 0; g < 6; g++) begin
            mid();
            chk("fair_grant", 32'(req_ready), 32'(1 << (g % 4)));
            step();
            mid();
            chk("fair_calc_rsp_valid", 32'(rsp_valid), 0);
            step();
            mid();
            chk("fair_rsp_valid", 32'(rsp_valid), 1);
            chk("fair_rsp_id", 32'(rsp_id), 32'(g % 4));
            chk("fair_rsp_result", 32'(rsp_result), 32'(2 * (g % 4) + 1));
            step();
        end
        req_valid = '0;

        // rr_ptr is 2: one grant to 2 moves it to 3, then 1 and 3 contend
        set_req(2, 1'b0, 4'd9, 4'd7);
        req_valid = 4'b0100;
        mid();
        chk("restart_grant2", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        step();
        mid();
        chk("restart_rsp2_result", 32'(rsp_result), 16);
        step();
        set_req(1, 1'b0, 4'd1, 4'd1);
        set_req(3, 1'b1, 4'd2, 4'd7);
        req_valid = 4'b1010;
        mid();
        chk("restart_grant3_first", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0010;
        step();
        mid();
        chk("restart_rsp3_result", 32'(rsp_result), 5);
        step();
        mid();
        chk("restart_grant1_second", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        step();
        mid();
        chk("restart_rsp1_id", 32'(rsp_id), 1);
        step();

        // back-pressure: rr_ptr is 2, request 0 waits behind the held response
        set_req(2, 1'b0, 4'd9, 4'd7);
        set_req(0, 1'b0, 4'd1, 4'd2);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        mid();
        chk("bp_grant2", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0001;
        step();
        for (int c = 0; c < 10; c++) begin
            mid();
            chk("bp_hold_valid", 32'(rsp_valid), 1);
            chk("bp_hold_id", 32'(rsp_id), 2);
            chk("bp_hold_result", 32'(rsp_result), 16);
            chk("bp_no_ready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        mid();
        chk("bp_handshake_valid", 32'(rsp_valid), 1);
        step();
        mid();
        chk("bp_next_grant0", 32'(req_ready), 32'b0001);
        chk("bp_valid_cleared", 32'(rsp_valid), 0);
        step();
        req_valid = '0;
        step();
        mid();
        chk("bp_rsp0_result", 32'(rsp_result), 3);
        chk("bp_rsp0_id", 32'(rsp_id), 0);
        step();

        // reset during CALC: rr_ptr was moved to 3, so only a reset pointer grants 1 before 3
        set_req(2, 1'b0, 4'd9, 4'd7);
        req_valid = 4'b0100;
        mid();
        chk("rst_grant2", 32'(req_ready), 32'b0100);
        step();
        set_req(1, 1'b0, 4'd4, 4'd4);
        set_req(3, 1'b0, 4'd1, 4'd1);
        req_valid = 4'b1010;
        reset = 1'b1;
        mid();
        chk("rst_calc_rsp_valid", 32'(rsp_valid), 0);
        step();
        reset = 1'b0;
        mid();
        chk("rst_after_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_after_grant1", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        mid();
        chk("rst_calc2_rsp_valid", 32'(rsp_valid), 0);
        step();
        mid();
        chk("rst_rsp_valid", 32'(rsp_valid), 1);
        chk("rst_rsp_id", 32'(rsp_id), 1);
        chk("rst_rsp_result", 32'(rsp_result), 8);
        step();
        mid();
        chk("rst_idle_valid", 32'(rsp_valid), 0);
        step();

`ifdef ADDSUB_ARB_STATS_EN
        set_req(0, 1'b0, 4'd1, 4'd1);
        req_valid = 4'b0001;
        for (int n = 0; n < 300; n++) begin
            mid();
            chk("stats_busy_arb", 32'(busy), 0);
            step();
            mid();
            chk("stats_busy_calc", 32'(busy), 1);
            step();
            mid();
            chk("stats_busy_resp", 32'(busy), 1);
            step();
        end
        req_valid = '0;
        mid();
        chk("stats_op_count_sat", 32'(op_count), 255);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
